amm_trans_gen: RTL and testbench

AMM_TRANS_GEN -- requirements
Module: amm_trans_gen

---
 rtl/settings_pkg.sv | 23 ++
 rtl/amm_pattern_gen.sv | 16 +
 rtl/amm_trans_gen.sv | 175 +++++++++++++++++
 tb/tb_amm_trans_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/settings_pkg.sv
// Shared types and default widths for the Avalon-MM transaction generator.
package settings_pkg;

  localparam int DATA_W        = 128;
  localparam int AMM_BURST_W   = 8;
  localparam int BYTE_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {
    MODE_WR    = 2'd0,
    MODE_RD    = 2'd1,
    MODE_WR_RD = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BURST,
    ST_RD_REQ,
    ST_RD_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/amm_pattern_gen.sv
// Maps a word address to its test pattern: the address, zero-extended to 32 bits,
// repeated in every 32-bit lane of the data word.
module amm_pattern_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);

  logic [31:0] lane;

  assign lane    = 32'(addr);
  assign pattern = {(DATA_W / 32){lane}};

endmodule

// File: rtl/amm_trans_gen.sv
// Avalon-MM burst traffic generator: writes an address pattern, reads it back,
// and counts read words that do not match.
module amm_trans_gen
  import settings_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = settings_pkg::DATA_W,
  parameter int AMM_BURST_W = settings_pkg::AMM_BURST_W,
  parameter int MAX_OUTST   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_test_i,
  input  logic [1:0]             mode_i,
  input  logic [ADDR_W-1:0]      start_addr_i,
  input  logic [AMM_BURST_W-1:0] burst_len_i,
  input  logic [15:0]            trans_num_i,
  output logic [ADDR_W-1:0]      address_o,
  output logic                   write_o,
  output logic                   read_o,
  output logic [AMM_BURST_W-1:0] burstcount_o,
  output logic [DATA_W/8-1:0]    byteenable_o,
  output logic [DATA_W-1:0]      writedata_o,
  input  logic                   waitrequest_i,
  input  logic                   readdatavalid_i,
  input  logic [DATA_W-1:0]      readdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            err_cnt_o
);

  localparam int OUTST_W = $clog2(MAX_OUTST + 1);

  state_e                 state, next_state;
  mode_e                  mode_in;
  logic                   wr_then_rd;
  logic [ADDR_W-1:0]      start_addr, burst_addr, rd_addr, wr_word_addr;
  logic [AMM_BURST_W-1:0] burst_len, beat_cnt, rd_beat;
  logic [15:0]            trans_num, burst_cnt;
  logic [OUTST_W-1:0]     outst_cnt;
  logic [31:0]            err_cnt;
  logic                   busy;
  logic                   start_acc, wr_acc, rd_acc, rd_word, rd_last;
  logic                   last_beat, last_burst, rd_mismatch, wr_state, rd_state;
  logic [DATA_W-1:0]      wr_pattern, rd_pattern;

  assign mode_in      = mode_e'(mode_i);
  assign start_acc    = (state == ST_IDLE) && start_test_i;
  assign wr_acc       = write_o && !waitrequest_i;
  assign rd_acc       = read_o && !waitrequest_i;
  assign last_beat    = (beat_cnt == burst_len - AMM_BURST_W'(1));
  assign last_burst   = (burst_cnt == trans_num - 16'd1);
  assign rd_word      = readdatavalid_i && ((state == ST_RD_REQ) || (state == ST_RD_DRAIN));
  assign rd_last      = rd_word && (rd_beat == burst_len - AMM_BURST_W'(1));
  assign rd_mismatch  = rd_word && (readdata_i != rd_pattern);
  assign wr_word_addr = burst_addr + ADDR_W'(beat_cnt);
  assign busy_o       = busy;
  assign err_cnt_o    = err_cnt;

  amm_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pattern (
    .addr    (wr_word_addr),
    .pattern (wr_pattern)
  );

  amm_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_pattern (
    .addr    (rd_addr),
    .pattern (rd_pattern)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:
        if (start_test_i) begin
          if (trans_num_i == 16'd0)     next_state = ST_DONE;
          else if (mode_in == MODE_RD)  next_state = ST_RD_REQ;
          else                          next_state = ST_WR_BURST;
        end
      ST_WR_BURST:
        if (wr_acc && last_beat && last_burst) next_state = wr_then_rd ? ST_RD_REQ : ST_DONE;
      ST_RD_REQ:
        if (rd_acc && last_burst) next_state = ST_RD_DRAIN;
      ST_RD_DRAIN:
        if (outst_cnt == '0) next_state = ST_DONE;
      ST_DONE:
        next_state = ST_IDLE;
      default:
        next_state = ST_IDLE;
    endcase
  end

  // Read requests stall while the outstanding window is full; this can only
  // happen between commands, so a raised read_o is never withdrawn.
  always_comb begin
    wr_state     = (state == ST_WR_BURST);
    rd_state     = (state == ST_RD_REQ) && (outst_cnt < OUTST_W'(MAX_OUTST));
    write_o      = wr_state;
    read_o       = rd_state;
    done_o       = (state == ST_DONE);
    address_o    = burst_addr;
    burstcount_o = (wr_state || rd_state) ? burst_len : '0;
    byteenable_o = wr_state ? '1 : '0;
    writedata_o  = wr_state ? wr_pattern : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_then_rd <= 1'b0;
      start_addr <= '0;
      burst_addr <= '0;
      burst_len  <= '0;
      trans_num  <= '0;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
    end else if (start_acc) begin
      wr_then_rd <= (mode_in == MODE_WR_RD);
      start_addr <= start_addr_i;
      burst_addr <= start_addr_i;
      burst_len  <= (burst_len_i == '0) ? AMM_BURST_W'(1) : burst_len_i;
      trans_num  <= trans_num_i;
      beat_cnt   <= '0;
      burst_cnt  <= '0;
    end else if (wr_acc) begin
      if (last_beat) begin
        beat_cnt <= '0;
        if (last_burst) begin
          burst_addr <= start_addr;
          burst_cnt  <= '0;
        end else begin
          burst_addr <= burst_addr + ADDR_W'(burst_len);
          burst_cnt  <= burst_cnt + 16'd1;
        end
      end else begin
        beat_cnt <= beat_cnt + AMM_BURST_W'(1);
      end
    end else if (rd_acc) begin
      burst_addr <= burst_addr + ADDR_W'(burst_len);
      burst_cnt  <= burst_cnt + 16'd1;
    end
  end

  // Read data returns in order and bursts are contiguous, so the expected
  // address simply advances by one word per returned beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_addr   <= '0;
      rd_beat   <= '0;
      outst_cnt <= '0;
      err_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (next_state != ST_IDLE) && (next_state != ST_DONE);
      if (start_acc) begin
        rd_addr <= start_addr_i;
        rd_beat <= '0;
      end else if (rd_word) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        rd_beat <= rd_last ? '0 : rd_beat + AMM_BURST_W'(1);
      end
      case ({rd_acc, rd_last})
        2'b10:   outst_cnt <= outst_cnt + OUTST_W'(1);
        2'b01:   outst_cnt <= outst_cnt - OUTST_W'(1);
        default: outst_cnt <= outst_cnt;
      endcase
      if (start_acc)                        err_cnt <= '0;
      else if (rd_mismatch && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_amm_trans_gen.sv
// Self-checking bench: a scoreboard of expected write beats and read commands,
// plus a latency-programmable Avalon-MM slave model answering reads.
module tb_amm_trans_gen;

  typedef struct { logic [31:0] baddr; logic [31:0] word; logic [7:0] len; } wr_exp_t;
  typedef struct { logic [31:0] baddr; logic [7:0] len; } rd_exp_t;
  typedef struct { logic [31:0] baddr; int len; int due; } resp_t;

  logic         clk, rst, start_test;
  logic [1:0]   mode;
  logic [31:0]  start_addr;
  logic [7:0]   burst_len;
  logic [15:0]  trans_num;
  logic [31:0]  address_o;
  logic         write_o, read_o;
  logic [7:0]   burstcount_o;
  logic [15:0]  byteenable_o;
  logic [127:0] writedata_o;
  logic         waitreq, rvalid;
  logic [127:0] rdata;
  logic         busy_o, done_o;
  logic [31:0]  err_cnt_o;

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, latency = 4, corrupt_left = 0, resp_beat = 0;
  int bench_outst = 0, max_outst = 0, outst_viol = 0, drop_viol = 0;
  int wr_beats = 0, rd_cmds = 0, wr_left = 0;
  bit rand_wait = 0, stray = 0, rd_pend = 0;
  logic [31:0] last_wr_addr = '0;
  wr_exp_t exp_wr[$];
  rd_exp_t exp_rd[$];
  resp_t   resp_q[$];

  amm_trans_gen dut (
    .clk_i(clk), .rst_i(rst), .start_test_i(start_test), .mode_i(mode),
    .start_addr_i(start_addr), .burst_len_i(burst_len), .trans_num_i(trans_num),
    .address_o(address_o), .write_o(write_o), .read_o(read_o),
    .burstcount_o(burstcount_o), .byteenable_o(byteenable_o), .writedata_o(writedata_o),
    .waitrequest_i(waitreq), .readdatavalid_i(rvalid), .readdata_i(rdata),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] exp_pattern(input logic [31:0] a);
    logic [127:0] p;
    for (int l = 0; l < 4; l++) p[l*32 +: 32] = a;
    return p;
  endfunction

  // Slave model and scoreboard: drives responses at the falling edge, then
  // inspects the request that the next rising edge will accept.
  initial begin
    wr_exp_t we;
    rd_exp_t re;
    resp_t   rs;
    int      inc, dec;
    waitreq = 1'b0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      inc = 0; dec = 0;
      waitreq = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      rvalid = 1'b0; rdata = '0;
      if (stray) begin
        rvalid = 1'b1; rdata = '1;
      end else if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        rvalid = 1'b1;
        rdata  = exp_pattern(resp_q[0].baddr + 32'(resp_beat));
        if (corrupt_left > 0) begin
          rdata[0] = ~rdata[0];
          corrupt_left--;
        end
        if (resp_beat == resp_q[0].len - 1) begin
          resp_beat = 0;
          void'(resp_q.pop_front());
          dec = 1;
        end else begin
          resp_beat++;
        end
      end
      #1;
      if (read_o && bench_outst >= 4) outst_viol++;
      if (wr_left > 0 && !write_o) drop_viol++;
      if (rd_pend && !read_o) drop_viol++;
      rd_pend = read_o && waitreq;
      if (write_o && !waitreq) begin
        tests_run++;
        if (exp_wr.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL wr_unexpected: got write at %0h, expected no write", address_o);
        end else begin
          we = exp_wr.pop_front();
          if (address_o !== we.baddr || burstcount_o !== we.len ||
              writedata_o !== exp_pattern(we.word) || byteenable_o !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL wr_beat: got addr %0h cnt %0d data %0h be %0h, expected addr %0h cnt %0d data %0h be ffff",
                     address_o, burstcount_o, writedata_o, byteenable_o, we.baddr, we.len, exp_pattern(we.word));
          end
        end
        if (wr_left == 0) wr_left = int'(burstcount_o);
        wr_left--;
        wr_beats++;
        last_wr_addr = address_o;
      end
      if (read_o && !waitreq) begin
        tests_run++;
        if (exp_rd.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL rd_unexpected: got read at %0h, expected no read", address_o);
        end else begin
          re = exp_rd.pop_front();
          if (address_o !== re.baddr || burstcount_o !== re.len) begin
            tests_failed++;
            $display("[TB] FAIL rd_cmd: got addr %0h cnt %0d, expected addr %0h cnt %0d",
                     address_o, burstcount_o, re.baddr, re.len);
          end
        end
        rs.baddr = address_o; rs.len = int'(burstcount_o); rs.due = cyc + latency;
        resp_q.push_back(rs);
        inc = 1;
        rd_cmds++;
      end
      bench_outst = bench_outst + inc - dec;
      if (bench_outst > max_outst) max_outst = bench_outst;
    end
  end

  task automatic launch(input logic [1:0] m, input logic [31:0] a, input logic [7:0] len,
                        input logic [15:0] num);
    logic [7:0]  eff;
    logic [31:0] baddr;
    wr_exp_t     we;
    rd_exp_t     re;
    eff = (len == 8'd0) ? 8'd1 : len;
    for (int b = 0; b < int'(num); b++) begin
      baddr = a + 32'(b) * 32'(eff);
      if (m != 2'd1)
        for (int k = 0; k < int'(eff); k++) begin
          we.baddr = baddr; we.word = baddr + 32'(k); we.len = eff;
          exp_wr.push_back(we);
        end
      if (m == 2'd1 || m == 2'd2) begin
        re.baddr = baddr; re.len = eff;
        exp_rd.push_back(re);
      end
    end
    @(negedge clk);
    mode = m; start_addr = a; burst_len = len; trans_num = num; start_test = 1'b1;
  endtask

  task automatic wait_done(input int repulse, output int cycles, output logic busy1,
                           output logic busy_done, output logic [31:0] err1, output bit timed_out);
    cycles = 0; timed_out = 1; busy1 = 1'b0; busy_done = 1'b1; err1 = '1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        start_test = 1'b0; busy1 = busy_o; err1 = err_cnt_o;
      end
      if (cycles == repulse) begin
        start_test = 1'b1; start_addr = 32'hDEAD0000; mode = 2'd1;
      end else if (cycles == repulse + 1) begin
        start_test = 1'b0;
      end
      if (done_o) begin
        busy_done = busy_o; timed_out = 0;
        break;
      end
    end
    start_test = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_test = 1'b0; mode = '0; start_addr = '0; burst_len = '0; trans_num = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (write_o !== 1'b0 || read_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req: got write %b read %b, expected 0 0", write_o, read_o);
    end
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got busy %b done %b, expected 0 0", busy_o, done_o);
    end
    tests_run++;
    if (address_o !== '0 || burstcount_o !== '0 || byteenable_o !== '0 || writedata_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: got addr %0h cnt %0h be %0h data %0h, expected all 0",
               address_o, burstcount_o, byteenable_o, writedata_o);
    end
    tests_run++;
    if (err_cnt_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_err: got %0d, expected 0", err_cnt_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_only();
    int cycles, w0; logic b1, bd; logic [31:0] e1; bit to;
    rand_wait = 0; w0 = wr_beats;
    launch(2'd0, 32'h100, 8'd4, 16'd2);
    wait_done(4, cycles, b1, bd, e1, to);
    tests_run++;
    if (to || cycles != 9) begin
      tests_failed++;
      $display("[TB] FAIL wo_done_time: got %0d cycles (timeout %0d), expected 9", cycles, to);
    end
    tests_run++;
    if (b1 !== 1'b1 || bd !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wo_busy: got busy %b after start, %b at done, expected 1 then 0", b1, bd);
    end
    tests_run++;
    if (wr_beats - w0 != 8 || exp_wr.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL wo_beats: got %0d beats, %0d left, expected 8 and 0", wr_beats - w0, exp_wr.size());
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (read_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wo_restart_ignored: got read %b busy %b, expected 0 0", read_o, busy_o);
    end
  endtask

  task automatic test_read_latency();
    int cycles, r0; logic b1, bd; logic [31:0] e1; bit to;
    rand_wait = 0; latency = 20; max_outst = 0; outst_viol = 0; r0 = rd_cmds;
    launch(2'd1, 32'h40, 8'd1, 16'd8);
    wait_done(0, cycles, b1, bd, e1, to);
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("[TB] FAIL rd_timeout: got no done_o, expected done within 3000 cycles");
    end
    tests_run++;
    if (outst_viol != 0 || max_outst != 4) begin
      tests_failed++;
      $display("[TB] FAIL rd_outstanding: got %0d reads at limit, peak %0d, expected 0 and 4", outst_viol, max_outst);
    end
    tests_run++;
    if (err_cnt_o !== 32'd0 || rd_cmds - r0 != 8 || exp_rd.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rd_result: got err %0d cmds %0d left %0d, expected 0 8 0", err_cnt_o, rd_cmds - r0, exp_rd.size());
    end
  endtask

  task automatic test_corrupt();
    int cycles; logic b1, bd; logic [31:0] e1; bit to;
    rand_wait = 0; latency = 5; corrupt_left = 3;
    launch(2'd1, 32'h300, 8'd2, 16'd4);
    wait_done(0, cycles, b1, bd, e1, to);
    tests_run++;
    if (to || err_cnt_o !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL corrupt_err: got %0d (timeout %0d), expected 3", err_cnt_o, to);
    end
    stray = 1;
    repeat (3) @(negedge clk);
    stray = 0;
    @(negedge clk);
    tests_run++;
    if (err_cnt_o !== 32'd3) begin
      tests_failed++;
      $display("[TB] FAIL stray_ignored: got err %0d, expected 3", err_cnt_o);
    end
  endtask

  task automatic test_write_read();
    int cycles, w0, r0; logic b1, bd; logic [31:0] e1; bit to;
    rand_wait = 1; latency = 3; drop_viol = 0; w0 = wr_beats; r0 = rd_cmds;
    launch(2'd2, 32'h200, 8'd2, 16'd3);
    wait_done(0, cycles, b1, bd, e1, to);
    rand_wait = 0;
    tests_run++;
    if (e1 !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_err_clear: got %0d after start, expected 0", e1);
    end
    tests_run++;
    if (to || drop_viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_hold: got %0d dropped requests (timeout %0d), expected 0", drop_viol, to);
    end
    tests_run++;
    if (wr_beats - w0 != 6 || rd_cmds - r0 != 3 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_count: got %0d writes %0d reads, expected 6 and 3", wr_beats - w0, rd_cmds - r0);
    end
    tests_run++;
    if (err_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL wr_rd_err: got %0d, expected 0", err_cnt_o);
    end
  endtask

  task automatic test_wrap();
    int cycles; logic b1, bd; logic [31:0] e1; bit to;
    rand_wait = 0;
    launch(2'd0, 32'hFFFFFFFE, 8'd4, 16'd2);
    wait_done(0, cycles, b1, bd, e1, to);
    tests_run++;
    if (to || last_wr_addr !== 32'h2 || exp_wr.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_addr: got last burst %0h, expected 2", last_wr_addr);
    end
  endtask

  task automatic test_boundaries();
    int cycles, w0, r0; logic b1, bd; logic [31:0] e1; bit to;
    w0 = wr_beats; r0 = rd_cmds;
    launch(2'd2, 32'h500, 8'd3, 16'd0);
    wait_done(0, cycles, b1, bd, e1, to);
    tests_run++;
    if (to || cycles != 1 || wr_beats != w0 || rd_cmds != r0 || bd !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_trans: got %0d cycles %0d beats %0d reads, expected 1 0 0",
               cycles, wr_beats - w0, rd_cmds - r0);
    end
    w0 = wr_beats;
    launch(2'd3, 32'h600, 8'd0, 16'd3);
    wait_done(0, cycles, b1, bd, e1, to);
    tests_run++;
    if (to || cycles != 4 || wr_beats - w0 != 3 || exp_wr.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL len_zero: got %0d cycles %0d beats, expected 4 and 3", cycles, wr_beats - w0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cycles, w0; logic b1, bd; logic [31:0] e1; bit to;
    rand_wait = 0;
    launch(2'd0, 32'h1000, 8'd8, 16'd4);
    @(negedge clk);
    start_test = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (write_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_write: got %b, expected 1", write_o);
    end
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if (write_o !== 1'b0 || busy_o !== 1'b0 || address_o !== '0 || writedata_o !== '0 ||
        byteenable_o !== '0 || burstcount_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got write %b busy %b addr %0h be %0h, expected all 0",
               write_o, busy_o, address_o, byteenable_o);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (write_o !== 1'b0 || read_o !== 1'b0 || done_o !== 1'b0 || err_cnt_o !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_edge: got write %b read %b done %b err %0d, expected 0",
               write_o, read_o, done_o, err_cnt_o);
    end
    exp_wr.delete(); exp_rd.delete(); resp_q.delete();
    wr_left = 0; resp_beat = 0; bench_outst = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w0 = wr_beats;
    launch(2'd0, 32'h20, 8'd3, 16'd2);
    wait_done(0, cycles, b1, bd, e1, to);
    tests_run++;
    if (to || cycles != 7 || wr_beats - w0 != 6 || exp_wr.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_run: got %0d cycles %0d beats, expected 7 and 6", cycles, wr_beats - w0);
    end
  endtask

  initial begin
    test_reset();
    test_write_only();
    test_read_latency();
    test_corrupt();
    test_write_read();
    test_wrap();
    test_boundaries();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
